// File: rtl/coor_pkg.sv
// Shared fixed-point widths and output tdata field layout for the coordinate
// address generator and the bilinear interpolation stage that consumes it.
package coor_pkg;

    localparam int COOR_W = 16;
    localparam int FRAC_W = 4;
    localparam int ADDR_W = 20;

    // m_axis_tdata = {oob, frac_y, frac_x, addr}
    localparam int ADDR_LSB  = 0;
    localparam int FRACX_LSB = ADDR_LSB + ADDR_W;
    localparam int FRACY_LSB = FRACX_LSB + FRAC_W;
    localparam int OOB_BIT   = FRACY_LSB + FRAC_W;
    localparam int TDATA_W   = OOB_BIT + 1;

endpackage

// File: rtl/axis_pipe_reg.sv
// Single valid/ready register slice; the enable depends only on the slice's
// own occupancy and the downstream ready, so in_ready never looks at in_valid.
module axis_pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_data  <= in_data;
        end
    end

endmodule

// File: rtl/coor_addr_gen.sv
// Turns warped fixed-point source coordinates into the top-left bilinear
// neighbour address, fractional weights and an out-of-bounds flag (2-stage pipe).
module coor_addr_gen #(
    parameter int ROW    = 4,
    parameter int COL    = 6,
    parameter int COOR_W = coor_pkg::COOR_W,
    parameter int FRAC_W = coor_pkg::FRAC_W,
    parameter int ADDR_W = coor_pkg::ADDR_W
) (
    input  logic                       s_axis_aclk,
    input  logic                       s_axis_aresetn,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [2*COOR_W-1:0]        s_axis_tdata,
    input  logic                       s_axis_tlast,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [ADDR_W+2*FRAC_W:0]   m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic                       frame_err
);

    localparam int IW    = COOR_W - FRAC_W;
    localparam int BEATS = ROW * COL;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int S1_W  = 2 + 2*FRAC_W + 2*IW;
    localparam int OUT_W = ADDR_W + 2*FRAC_W + 1;
    localparam int S2_W  = OUT_W + 1;

    localparam logic signed [IW-1:0] X_MAX = IW'(COL - 2);
    localparam logic signed [IW-1:0] Y_MAX = IW'(ROW - 2);

    logic signed [IW-1:0] x_int, y_int;
    logic [FRAC_W-1:0]    frac_x, frac_y;
    logic                 oob;
    logic [S1_W-1:0]      s1_din, s1_q;
    logic                 v1, en2;

    // Dropping the fraction bits of a two's complement value is a floor shift.
    assign x_int  = $signed(s_axis_tdata[COOR_W-1:FRAC_W]);
    assign y_int  = $signed(s_axis_tdata[2*COOR_W-1:COOR_W+FRAC_W]);
    assign frac_x = s_axis_tdata[FRAC_W-1:0];
    assign frac_y = s_axis_tdata[COOR_W+FRAC_W-1:COOR_W];
    assign oob    = x_int[IW-1] | (x_int > X_MAX) | y_int[IW-1] | (y_int > Y_MAX);
    assign s1_din = {s_axis_tlast, oob, frac_y, frac_x, y_int, x_int};

    axis_pipe_reg #(.W(S1_W)) u_s1 (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .in_valid  (s_axis_tvalid),
        .in_ready  (s_axis_tready),
        .in_data   (s1_din),
        .out_valid (v1),
        .out_ready (en2),
        .out_data  (s1_q)
    );

    logic [IW-1:0]     s1_x, s1_y;
    logic [FRAC_W-1:0] s1_fx, s1_fy;
    logic              s1_oob, s1_last;
    logic [ADDR_W-1:0] addr_lin;
    logic [S2_W-1:0]   s2_din, s2_q;

    assign s1_x    = s1_q[IW-1:0];
    assign s1_y    = s1_q[2*IW-1:IW];
    assign s1_fx   = s1_q[2*IW +: FRAC_W];
    assign s1_fy   = s1_q[2*IW+FRAC_W +: FRAC_W];
    assign s1_oob  = s1_q[2*IW+2*FRAC_W];
    assign s1_last = s1_q[S1_W-1];

    // Only consumed when in bounds, so both integer parts are non-negative here.
    assign addr_lin = ADDR_W'(s1_y) * ADDR_W'(COL) + ADDR_W'(s1_x);
    assign s2_din   = s1_oob ? {s1_last, 1'b1, {(2*FRAC_W+ADDR_W){1'b0}}}
                             : {s1_last, 1'b0, s1_fy, s1_fx, addr_lin};

    axis_pipe_reg #(.W(S2_W)) u_s2 (
        .clk       (s_axis_aclk),
        .rst_n     (s_axis_aresetn),
        .in_valid  (v1),
        .in_ready  (en2),
        .in_data   (s2_din),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (s2_q)
    );

    assign m_axis_tdata = s2_q[OUT_W-1:0];
    assign m_axis_tlast = s2_q[S2_W-1];

    logic [CNT_W-1:0] beat_cnt;
    logic             in_hs, at_last;

    assign in_hs   = s_axis_tvalid & s_axis_tready;
    assign at_last = (beat_cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            beat_cnt  <= '0;
            frame_err <= 1'b0;
        end else if (in_hs) begin
            beat_cnt <= (s_axis_tlast | at_last) ? '0 : beat_cnt + CNT_W'(1);
            if (s_axis_tlast != at_last)
                frame_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_coor_addr_gen.sv
// Randomized and directed bench for coor_addr_gen against a queue-based
// reference model of the coordinate-to-address mapping and framing rules.
module tb_coor_addr_gen;
    import coor_pkg::*;

    localparam int ROW = 4;
    localparam int COL = 6;
    localparam int DW  = TDATA_W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [31:0]   s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          frame_err;

    always #5 clk = ~clk;

    coor_addr_gen #(.ROW(ROW), .COL(COL), .COOR_W(COOR_W), .FRAC_W(FRAC_W), .ADDR_W(ADDR_W)) dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tdata   (s_tdata),
        .s_axis_tlast   (s_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tlast   (m_tlast),
        .frame_err      (frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: integer part = floor(v/16), fraction = v mod 16.
    function automatic logic [DW-1:0] ref_word(logic [15:0] x, logic [15:0] y);
        int xs, ys, fx, fy, xi, yi, addr;
        bit oob;
        logic [DW-1:0] w;
        xs = int'($signed(x));
        ys = int'($signed(y));
        fx = xs & 15;
        fy = ys & 15;
        xi = (xs - fx) / 16;
        yi = (ys - fy) / 16;
        oob = (xi < 0) || (xi > COL - 2) || (yi < 0) || (yi > ROW - 2);
        addr = yi * COL + xi;
        w = '0;
        w[OOB_BIT] = oob;
        if (!oob) begin
            w[ADDR_LSB +: ADDR_W]  = ADDR_W'(addr);
            w[FRACX_LSB +: FRAC_W] = FRAC_W'(fx);
            w[FRACY_LSB +: FRAC_W] = FRAC_W'(fy);
        end
        return w;
    endfunction

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            ld_cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   out_cnt = 0;
    int   beat_m = 0;
    bit   err_m = 0;
    bit   exp_v;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            beat_m = 0;
            err_m  = 0;
            chk("rst_mvalid", m_tvalid, 0);
            chk("rst_mdata", m_tdata, 0);
            chk("rst_mlast", m_tlast, 0);
            chk("rst_frame_err", frame_err, 0);
        end else begin
            exp_v = (q.size() > 0) && (cyc >= q[0].ld_cyc + 1);
            chk("m_tvalid", m_tvalid, exp_v);
            chk("s_tready", s_tready, !(q.size() == 2 && !m_tready));
            chk("frame_err", frame_err, err_m);
            if (m_tvalid && exp_v) begin
                chk("m_tdata", m_tdata, q[0].data);
                chk("m_tlast", m_tlast, q[0].last);
                if (m_tready) begin
                    void'(q.pop_front());
                    out_cnt++;
                end
            end
            if (s_tvalid && s_tready) begin
                q.push_back('{data: ref_word(s_tdata[15:0], s_tdata[31:16]),
                              last: s_tlast, ld_cyc: cyc + 1});
                if (s_tlast != (beat_m == ROW*COL - 1)) err_m = 1;
                beat_m = (s_tlast || beat_m == ROW*COL - 1) ? 0 : beat_m + 1;
            end
        end
    end

    // Downstream ready: 0 = always on, 1 = fixed stall pattern, 2 = random.
    int rdy_mode = 0;
    int pidx = 0;
    bit pat[6] = '{1, 1, 1, 0, 1, 0};

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                1: begin
                    m_tready = (pidx < 6) ? pat[pidx] : 1'b1;
                    pidx++;
                end
                2: m_tready = ($urandom_range(0, 3) != 0);
                default: m_tready = 1'b1;
            endcase
        end
    end

    task automatic send(logic [15:0] x, logic [15:0] y, logic last);
        int n = 0;
        bit hs = 0;
        s_tvalid = 1'b1;
        s_tdata  = {y, x};
        s_tlast  = last;
        do begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 1000);
        if (!hs) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(int n);
        s_tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(int n, int last_at, bit gaps);
        logic [15:0] x, y;
        for (int i = 0; i < n; i++) begin
            x = 16'($urandom_range(0, 160)) - 16'd32;
            y = 16'($urandom_range(0, 96)) - 16'd32;
            send(x, y, i == last_at);
            if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic directed(string tag, logic [15:0] x, logic [15:0] y,
                            int ea, int efx, int efy, int eo);
        send(x, y, 1'b0);
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, m_tvalid, 1);
        chk({tag, "_addr"}, m_tdata[ADDR_LSB +: ADDR_W], ea);
        chk({tag, "_fx"}, m_tdata[FRACX_LSB +: FRAC_W], efx);
        chk({tag, "_fy"}, m_tdata[FRACY_LSB +: FRAC_W], efy);
        chk({tag, "_oob"}, m_tdata[OOB_BIT], eo);
    endtask

    task automatic pulse_reset(int n);
        s_tvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", m_tvalid, 0);
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int base;
    int last_at;

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        directed("inb", 16'h0023, 16'h0010, 8, 3, 0, 0);
        directed("xneg", 16'hFFF0, 16'h0010, 0, 0, 0, 1);
        directed("xhi", 16'h0050, 16'h0010, 0, 0, 0, 1);
        directed("yhi", 16'h0010, 16'h0030, 0, 0, 0, 1);
        directed("edge", 16'h004F, 16'h0020, 16, 15, 0, 0);
        drain();
        pulse_reset(1);

        base = out_cnt;
        send_frame(24, 23, 0);
        drain();
        chk("stream_count", out_cnt - base, 24);
        chk("stream_frame_err", frame_err, 0);

        pidx = 0;
        rdy_mode = 1;
        base = out_cnt;
        send_frame(24, 23, 0);
        drain();
        rdy_mode = 0;
        chk("bp_count", out_cnt - base, 24);
        chk("bp_frame_err", frame_err, 0);

        send_frame(11, 10, 0);
        drain();
        chk("short_frame_err", frame_err, 1);
        send_frame(24, 23, 0);
        drain();
        chk("sticky_frame_err", frame_err, 1);

        send_frame(6, 99, 0);
        pulse_reset(2);
        chk("post_rst_frame_err", frame_err, 0);
        base = out_cnt;
        send_frame(24, 23, 0);
        drain();
        chk("post_rst_count", out_cnt - base, 24);
        chk("post_rst_frame_ok", frame_err, 0);

        rdy_mode = 2;
        for (int f = 0; f < 10; f++) begin
            last_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 22) : 23;
            send_frame(last_at + 1, last_at, 1);
        end
        drain();
        rdy_mode = 0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/coor_addr_gen.md
Name: coor_addr_gen

Overview:
- Downstream consumer of the coordinate warper's AXI-Stream output.
- Converts each warped fixed-point source coordinate (x, y) into three things:
  - the linear source-pixel address of the top-left bilinear neighbour,
  - the fractional weights for x and y,
  - an out-of-bounds flag.
- Feeds the pixel-fetch / bilinear interpolation stage.
- Fully pipelined: one coordinate per clock, backpressure honoured end to end.

Parameters:
- ROW, 4: source image rows.
- COL, 6: source image columns.
- COOR_W, 16: width of each signed fixed-point coordinate.
- FRAC_W, 4: fractional bits per coordinate.
- ADDR_W, 20: output address width; must satisfy 2^ADDR_W >= ROW*COL.

Ports:
- s_axis_aclk  in  1  single clock for both interfaces.
- s_axis_aresetn  in  1  asynchronous, active-low reset.
- s_axis_tvalid  in  1  input coordinate valid.
- s_axis_tready  out  1  input ready.
- s_axis_tdata  in  2*COOR_W  [COOR_W-1:0] = x, [2*COOR_W-1:COOR_W] = y; both signed two's complement Q(COOR_W-FRAC_W).FRAC_W.
- s_axis_tlast  in  1  last coordinate of frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  ADDR_W+2*FRAC_W+1  {oob, frac_y, frac_x, addr}, with addr in the LSBs.
- m_axis_tlast  out  1  tlast delayed to align with its data.
- frame_err  out  1  sticky tlast-framing error.

Behaviour:
- Reset (asynchronous assert on s_axis_aresetn=0, synchronous release):
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0.
  - frame_err=0, beat counter=0.
  - Both pipeline valid bits = 0.
  - s_axis_tready=1 from the first clock after release.
- Pipeline: two register stages, S1 and S2; latency is exactly 2 cycles from input handshake to m_axis_tvalid.
- Handshake / stall logic:
  - en2 = ~v2 | m_axis_tready.
  - en1 = ~v1 | en2.
  - s_axis_tready = en1 (combinational; no dependency on s_axis_tvalid).
- Throughput and ordering:
  - 1 beat/cycle while m_axis_tready=1.
  - No beat is dropped or duplicated under any tready pattern.
  - m_axis_tdata and m_axis_tlast are held stable while m_axis_tvalid=1 and m_axis_tready=0.
- S1, loaded when en1 is high:
  - v1 <= s_axis_tvalid.
  - x_int = x >>> FRAC_W (arithmetic shift, floor); y_int likewise.
  - frac_x = x[FRAC_W-1:0]; frac_y likewise.
  - oob = (x_int<0) | (x_int>COL-2) | (y_int<0) | (y_int>ROW-2). The bound is COL-2 / ROW-2 because the +1 neighbour must also be inside the image.
  - tlast is registered alongside.
- S2, loaded when en2 is high:
  - v2 <= v1.
  - addr = y_int*COL + x_int, truncated to ADDR_W; COL is a constant multiplier.
  - If oob=1: addr=0 and frac_x=frac_y=0, with oob still set.
- Beat counter (width clog2(ROW*COL)):
  - Increments on each input handshake (s_axis_tvalid & s_axis_tready).
  - Wraps to 0 after beat ROW*COL-1, or on a handshake with tlast=1.
- frame_err is set (sticky until reset) when either:
  - tlast=1 on a beat other than ROW*COL-1, or
  - tlast=0 on beat ROW*COL-1.
- Simultaneous events:
  - Input handshake together with an output handshake while both stages are full: S2 takes S1, and S1 takes the new input in the same cycle.
  - s_axis_tvalid=0 while en1 is high: a bubble enters, with no spurious output.
- Reset mid-frame: in-flight beats are discarded, counter returns to 0, frame_err is cleared.

Decomposition:
- Package coor_pkg holds:
  - fixed-point width constants (COOR_W, FRAC_W);
  - the output tdata field offsets (ADDR_LSB, FRACX_LSB, FRACY_LSB, OOB_BIT), shared with the interpolation stage.
- One natural sub-module: axis_pipe_reg, a single valid/ready register slice instantiated once per stage with the datapath logic between the two instances.

Test Plan:
- All scenarios use ROW=4, COL=6, FRAC_W=4.
- In-bounds beat: x=0x0023, y=0x0010 with tready=1 -> 2 cycles later tvalid=1, addr=8, frac_x=3, frac_y=0, oob=0.
- Bounds:
  - x=0xFFF0 (-1.0) -> oob=1, addr=0.
  - x=0x0050 (5.0 > COL-2) -> oob=1.
  - y=0x0030 (3.0 > ROW-2) -> oob=1.
  - x=0x004F, y=0x0020 -> addr=16, frac_x=15, oob=0.
- Streaming: 24-beat frame with tready held 1 and tlast on beat 23 -> 24 outputs on 24 consecutive cycles starting cycle 2, tlast only on the 24th, frame_err=0.
- Backpressure: same frame with tready pattern 3 on / 1 off / 1 on / 1 off / steady on -> identical output sequence, data stable during stalls, s_axis_tready=0 only while both stages are full and stalled.
- Framing error: tlast on beat 10 -> frame_err=1 and stays 1; the next frame restarts the counter at 0.
- Reset mid-frame: aresetn low for 2 cycles after beat 5 -> tvalid=0 immediately and no stale beats emitted; a fresh 24-beat frame then passes with frame_err=0.
